// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
// Optional write-to-read forwarding is selected with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int ZERO_ADDR          = 0;
    localparam int POP_MAX_WIDTH      = 256;

    // Population count over a zero-extended busy vector.
    function automatic int unsigned popcount(input logic [POP_MAX_WIDTH-1:0] vec);
        int unsigned n;
        n = 32'd0;
        for (int i = 0; i < POP_MAX_WIDTH; i++) begin
            n = n + {31'd0, vec[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, writeback, issue and scoreboard-status signals of the register file.
// The datapath side is the master; the register file is the slave.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_RD     = 2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [NUM_RD*ADDR_WIDTH-1:0] rd_sel;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic                         wr_en;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic                         issue_en;
    logic [ADDR_WIDTH-1:0]        issue_addr;
    logic [DEPTH-1:0]             busy_vec;
    logic [ADDR_WIDTH:0]          busy_cnt;

    modport master (
        output rd_sel, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        input  rd_data, rd_busy, busy_vec, busy_cnt
    );

    modport slave (
        input  rd_sel, wr_en, wr_addr, wr_data, issue_en, issue_addr,
        output rd_data, rd_busy, busy_vec, busy_cnt
    );

endinterface

// File: rtl/regfile_busy_tracker.sv
// Per-register busy bits with an incrementally maintained population count.
// At most one set and one clear arrive per edge; a coincident set/clear of one bit keeps it set.
module regfile_busy_tracker #(
    parameter int DEPTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DEPTH-1:0]     set_i,
    input  logic [DEPTH-1:0]     clr_i,
    output logic [DEPTH-1:0]     busy_vec_o,
    output logic [CNT_WIDTH-1:0] busy_cnt_o
);

    logic [DEPTH-1:0]     busy_q;
    logic [DEPTH-1:0]     busy_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 rise_s;
    logic                 fall_s;

    // Next busy state and count adjustment from the bits that actually toggle.
    always_comb begin
        busy_d = (busy_q & ~clr_i) | set_i;
        rise_s = |(busy_d & ~busy_q);
        fall_s = |(busy_q & ~busy_d);
        cnt_d  = cnt_q;
        if (rise_s && !fall_s) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (fall_s && !rise_s) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Busy bits and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with combinational read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_SEL = ADDR_WIDTH'(ZERO_ADDR);

    logic [DATA_WIDTH-1:0]        regs_q [DEPTH];
    logic [ADDR_WIDTH-1:0]        rd_sel_s [NUM_RD];
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data_s;
    logic [NUM_RD-1:0]            rd_busy_s;
    logic [DEPTH-1:0]             set_vec_s;
    logic [DEPTH-1:0]             clr_vec_s;
    logic [DEPTH-1:0]             busy_vec_s;
    logic [ADDR_WIDTH:0]          busy_cnt_s;
    logic                         wr_ok_s;

    assign wr_ok_s = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == ZERO_SEL));

    // Data array; the zero register is never written when it is hardwired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok_s) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end else begin
            regs_q[bus.wr_addr] <= regs_q[bus.wr_addr];
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_sel
        assign rd_sel_s[k] = bus.rd_sel[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Read muxes with zero-register masking and optional writeback forwarding.
    always_comb begin
        rd_data_s = '0;
        rd_busy_s = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if ((ZERO_REG != 0) && (rd_sel_s[k] == ZERO_SEL)) begin
                rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                rd_busy_s[k]                          = 1'b0;
            end
`ifdef REGFILE_BYPASS_EN
            else if (bus.wr_en && (bus.wr_addr == rd_sel_s[k])) begin
                rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
                rd_busy_s[k] = bus.issue_en && (bus.issue_addr == bus.wr_addr);
            end
`endif
            else begin
                rd_data_s[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_sel_s[k]];
                rd_busy_s[k]                          = busy_vec_s[rd_sel_s[k]];
            end
        end
    end

    // One-hot set/clear decode; the hardwired zero register is never reserved.
    always_comb begin
        set_vec_s = '0;
        clr_vec_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            set_vec_s[i] = bus.issue_en && (bus.issue_addr == ADDR_WIDTH'(i))
                           && ((ZERO_REG == 0) || (i != ZERO_ADDR));
            clr_vec_s[i] = bus.wr_en && (bus.wr_addr == ADDR_WIDTH'(i));
        end
    end

    regfile_busy_tracker #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (ADDR_WIDTH + 1)
    ) u_busy (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (set_vec_s),
        .clr_i      (clr_vec_s),
        .busy_vec_o (busy_vec_s),
        .busy_cnt_o (busy_cnt_s)
    );

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.busy_vec = busy_vec_s;
    assign bus.busy_cnt = busy_cnt_s;

endmodule
